// File: rtl/orangecrab_reset_pkg.sv
// Shared types and constants for the OrangeCrab board-reset request path.
package orangecrab_reset_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY1 = 2'd1,
        FIRE = 2'd2
    } state_t;

    localparam logic [7:0] UNLOCK_KEY0 = 8'h52;
    localparam logic [7:0] UNLOCK_KEY1 = 8'h53;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and stability-count debouncer for the active-low user button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic clk,
    input  logic nreset,
    input  logic btn_n,
    output logic pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic          deb_n;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= btn_n;
            sync1 <= sync0;
        end
    end

    // The count is of consecutive samples disagreeing with the debounced level;
    // the flip happens on the sample that brings it to DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            deb_n <= 1'b1;
            cnt   <= '0;
        end else if (sync1 == deb_n) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_n <= sync1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pressed = !deb_n;

endmodule

// File: rtl/orangecrab_reset_req.sv
// Board-reset request: long-press button path plus two-byte unlock command FSM.
module orangecrab_reset_req
    import orangecrab_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 480000,
    parameter int LONGPRESS_CYCLES = 96000000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       btn_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       do_reset,
    output logic       armed,
    output logic       cmd_err,
    output state_t     dbg_state
);

    localparam int PW = $clog2(LONGPRESS_CYCLES + 1);

    logic          pressed;
    logic [PW-1:0] press_cnt;
    logic          btn_trig;
    logic          accept;
    state_t        state;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .nreset (nreset),
        .btn_n  (btn_n),
        .pressed(pressed)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            press_cnt <= '0;
        end else if (!pressed) begin
            press_cnt <= '0;
        end else if (press_cnt != PW'(LONGPRESS_CYCLES)) begin
            press_cnt <= press_cnt + 1'b1;
        end
    end

    // Trigger on the edge where the press count reaches LONGPRESS_CYCLES, so the
    // FSM commits on that same edge.
    assign btn_trig = pressed && (press_cnt == PW'(LONGPRESS_CYCLES - 1));

    // Command stream: a byte transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on state, never on cmd_valid.
    assign cmd_ready = (state != FIRE);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            do_reset <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (state != FIRE) begin
                if (btn_trig) begin
                    state    <= FIRE;
                    do_reset <= 1'b1;
                end else if (accept) begin
                    unique case (state)
                        IDLE: begin
                            if (cmd_data == UNLOCK_KEY0) state <= KEY1;
                            else cmd_err <= 1'b1;
                        end
                        KEY1: begin
                            if (cmd_data == UNLOCK_KEY1) begin
                                state    <= FIRE;
                                do_reset <= 1'b1;
                            end else if (cmd_data != UNLOCK_KEY0) begin
                                state   <= IDLE;
                                cmd_err <= 1'b1;
                            end
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    assign armed     = (pressed || state == KEY1) && (state != FIRE);
    assign dbg_state = state;

endmodule

// File: tb/tb_orangecrab_reset_req.sv
// Self-checking bench for orangecrab_reset_req with small debounce/long-press counts.
module tb_orangecrab_reset_req;
  import orangecrab_reset_pkg::*;

  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       btn_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       do_reset;
  logic       armed;
  logic       cmd_err;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  // expected entry: {cmd_err, do_reset, state[1:0]}
  logic [3:0] exp_q[$];

  // reference model: unlock progress and commit flag
  bit m_key = 0;
  bit m_fired = 0;

  logic hs_pending = 1'b0;

  orangecrab_reset_req #(
    .DEBOUNCE_CYCLES (D),
    .LONGPRESS_CYCLES(L)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .btn_n    (btn_n),
    .cmd_valid(cmd_valid),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .do_reset (do_reset),
    .armed    (armed),
    .cmd_err  (cmd_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pack_exp(bit err);
    state_t s;
    s = m_fired ? FIRE : (m_key ? KEY1 : IDLE);
    return {err, m_fired, s};
  endfunction

  // model one accepted byte; btn_fire means the long press commits on the same edge
  function automatic logic [3:0] model_byte(logic [7:0] b, bit btn_fire);
    bit err;
    err = 0;
    if (btn_fire) begin
      m_fired = 1;
    end else if (!m_key) begin
      if (b == 8'h52) m_key = 1;
      else err = 1;
    end else if (b == 8'h53) begin
      m_fired = 1;
    end else if (b != 8'h52) begin
      m_key = 0;
      err = 1;
    end
    return pack_exp(err);
  endfunction

  // driver tasks: inputs change 2 time units after a rising edge
  task automatic send_byte(input logic [7:0] b, input bit btn_fire);
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_data  = b;
    if (!m_fired) exp_q.push_back(model_byte(b, btn_fire));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic sample_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    @(posedge clk);
    #3;
    nreset    = 1'b0;
    cmd_valid = 1'b0;
    btn_n     = 1'b1;
    check("queue_drained_at_reset", exp_q.size(), 0);
    exp_q.delete();
    m_key   = 0;
    m_fired = 0;
    repeat (2) @(posedge clk);
    #3;
    nreset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_do_reset"}, do_reset, 0);
    check({tag, "_armed"}, armed, 0);
    check({tag, "_cmd_err"}, cmd_err, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // drive btn_n low and count edges until armed; returns edge count (0 = never)
  task automatic press_until_armed(output int n);
    @(posedge clk);
    #2;
    btn_n = 1'b0;
    n = 0;
    for (int i = 1; i <= D + 10; i++) begin
      sample_cycle();
      if (armed) begin
        n = i;
        break;
      end
    end
  endtask

  // scoreboard monitor: handshake seen before the edge, compared just after it
  always @(negedge clk) hs_pending = nreset && cmd_valid && cmd_ready;

  always @(posedge clk) begin
    if (hs_pending) begin
      logic [3:0] e;
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: actual=accepted data=%0h required=no_accept", cmd_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd_err", cmd_err, e[3]);
        check("sb_do_reset", do_reset, e[2]);
        check("sb_state", dbg_state, e[1:0]);
      end
    end
  end

  initial begin : stim
    int n;
    int seen;
    int r;
    logic [7:0] b;

    // reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #3;
    nreset = 1'b1;
    sample_cycle();
    check_reset_outputs("post_reset");

    // unlock
    send_byte(8'h52, 0);
    send_byte(8'h53, 0);
    send_byte(8'h52, 0);
    send_byte(8'h53, 0);
    idle(1);
    #1;
    check("unlock_cmd_ready", cmd_ready, 0);
    check("unlock_do_reset", do_reset, 1);

    // bad sequence then recovery
    apply_reset();
    send_byte(8'h52, 0);
    send_byte(8'h41, 0);
    idle(1);
    sample_cycle();
    check("bad_err_one_cycle", cmd_err, 0);
    send_byte(8'h53, 0);
    idle(1);
    sample_cycle();
    check("bad_idle_state", dbg_state, IDLE);
    check("bad_no_reset", do_reset, 0);
    send_byte(8'h52, 0);
    send_byte(8'h52, 0);
    send_byte(8'h53, 0);
    idle(1);
    #1;
    check("retry_fires", do_reset, 1);

    // randomized byte stream
    for (int pass = 0; pass < 4; pass++) begin
      apply_reset();
      for (int i = 0; i < 40 && !m_fired; i++) begin
        r = $urandom_range(0, 7);
        if (r < 2) idle(1);
        else begin
          b = (r < 5) ? 8'h52 : (r < 7) ? 8'h53 : 8'($urandom_range(0, 255));
          send_byte(b, 0);
        end
      end
      send_byte(8'h52, 0);
      send_byte(8'h53, 0);
      idle(2);
      #1;
      check("rand_do_reset", do_reset, m_fired);
      check("rand_cmd_ready", cmd_ready, !m_fired);
    end

    // long press
    apply_reset();
    press_until_armed(n);
    check("lp_armed_in_window", (n >= D + 1 && n <= D + 3), 1);
    n = 0;
    for (int i = 1; i <= L + 5; i++) begin
      sample_cycle();
      if (do_reset) begin
        n = i;
        break;
      end
    end
    check("lp_press_to_reset", n, L);
    m_fired = 1;
    check("lp_armed_cleared", armed, 0);
    repeat (10) @(posedge clk);
    #2;
    btn_n = 1'b1;
    repeat (12) sample_cycle();
    check("lp_hold_after_release", do_reset, 1);
    check("lp_cmd_ready_low", cmd_ready, 0);
    send_byte(8'h52, 0);
    idle(2);

    // bounce, then short press
    apply_reset();
    seen = 0;
    for (int k = 0; k < 28; k++) begin
      @(posedge clk);
      #2;
      if (k < 20 && k % 2 == 0) btn_n = ~btn_n;
      if (armed) seen++;
    end
    check("bounce_never_armed", seen, 0);
    seen = 0;
    @(posedge clk);
    #2;
    btn_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2;
      if (armed) seen++;
    end
    btn_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #2;
      if (armed) seen++;
    end
    check("short_armed_pulsed", (seen > 0), 1);
    check("short_no_reset", do_reset, 0);
    check("short_armed_cleared", armed, 0);

    // button trigger coincides with a bad byte in IDLE
    apply_reset();
    press_until_armed(n);
    check("sim_armed_in_window", (n >= D + 1 && n <= D + 3), 1);
    repeat (L - 2) @(posedge clk);
    send_byte(8'h41, 1);
    idle(1);
    sample_cycle();
    check("sim_no_err_after", cmd_err, 0);
    check("sim_fired", do_reset, 1);
    btn_n = 1'b1;

    // reset mid-operation
    apply_reset();
    send_byte(8'h52, 0);
    idle(1);
    #1;
    check("mid_key1_state", dbg_state, KEY1);
    check("mid_key1_armed", armed, 1);
    nreset = 1'b0;
    #1;
    check_reset_outputs("mid_key1_async");
    m_key = 0;
    m_fired = 0;
    @(posedge clk);
    #3;
    nreset = 1'b1;
    send_byte(8'h53, 0);
    send_byte(8'h52, 0);
    send_byte(8'h53, 0);
    idle(1);
    #1;
    check("mid_refire", do_reset, 1);
    nreset = 1'b0;
    #1;
    check_reset_outputs("mid_fire_async");
    m_key = 0;
    m_fired = 0;
    @(posedge clk);
    #3;
    nreset = 1'b1;
    send_byte(8'h53, 0);
    idle(2);
    #1;
    check("mid_after_no_reset", do_reset, 0);

    check("queue_drained_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
